// File: rtl/wb_pkg.sv
// Shared state encoding and helpers for the round-robin Wishbone arbiter.
package wb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned MAX_IDX_W   = 3;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_OWNED = 1'b1;

  typedef logic [MAX_MASTERS-1:0] master_vec_t;

  // One-hot decode of a master index, sized for the largest supported arbiter.
  function automatic master_vec_t onehot(input logic [MAX_IDX_W-1:0] idx);
    master_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Master-side and slave-side Wishbone signals of the arbiter, bundled in one interface.
interface wb_arbiter_rr_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SEL_WIDTH   = 8
) ();

  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;
  logic [NUM_MASTERS-1:0]            gnt_o;
  logic                              busy_o;

  // Arbiter view.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
           gnt_o, busy_o
  );

  // Surrounding fabric view: drives the masters and the shared slave's responses.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
           gnt_o, busy_o
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after the last winner, wrapping.
module rr_picker #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic                   valid,
  output logic [IDX_W-1:0]       winner
);

  logic [31:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = (32'(last) + i) % NUM_MASTERS;
      if (!valid && req[IDX_W'(idx)]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone classic arbiter: one owner holds the slave for its whole CYC.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SEL_WIDTH   = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_arbiter_rr_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic [IDX_W-1:0]       last, last_nxt;
  logic [IDX_W-1:0]       pick;
  logic [NUM_MASTERS-1:0] gnt, gnt_nxt;
  logic                   pick_valid;
  logic                   busy;
  logic                   owner_cyc;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req    (bus.m_cyc_i),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick)
  );

  // Reset points last at the top index so master 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_OWNED;
          gnt_nxt   = NUM_MASTERS'(onehot(MAX_IDX_W'(pick)));
          owner_nxt = pick;
          last_nxt  = pick;
        end
      end
      ST_OWNED: begin
        if (!owner_cyc) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = (state == ST_OWNED);
  assign owner_cyc = bus.m_cyc_i[owner];

  // Slave side follows the owner only while owned; zero otherwise.
  assign bus.s_cyc_o = busy & owner_cyc;
  assign bus.s_stb_o = busy & owner_cyc & bus.m_stb_i[owner];
  assign bus.s_we_o  = busy & bus.m_we_i[owner];
  assign bus.s_adr_o = busy ? bus.m_adr_i[32'(owner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.s_dat_o = busy ? bus.m_dat_i[32'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.s_sel_o = busy ? bus.m_sel_i[32'(owner)*SEL_WIDTH +: SEL_WIDTH] : '0;

  // gnt is zero when idle, so it doubles as the busy-gated owner select for ACK.
  assign bus.m_ack_o = (owner_cyc & bus.s_ack_i) ? gnt : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt;
  assign bus.busy_o  = busy;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: directed scenarios plus randomized traffic vs a reference model.
module tb_wb_arbiter_rr;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 8;
  localparam int unsigned SLV_W = 3 + AW + DW + SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_rr_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();
  wb_arbiter_rr_if #(.NUM_MASTERS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus1 ();

  wb_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  wb_arbiter_rr #(.NUM_MASTERS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  // Shared slave for the 4-master arbiter: 16-word register file, ACK one cycle after a strobe.
  logic          ack_force;
  logic          slv_ack;
  logic [DW-1:0] slv_rdat;
  logic [DW-1:0] slv_mem [16];

  always @(posedge clk) begin
    if (rst) begin
      slv_ack  <= 1'b0;
      slv_rdat <= '0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else begin
      slv_ack  <= bus.s_cyc_o & bus.s_stb_o & ~slv_ack;
      slv_rdat <= slv_mem[bus.s_adr_o[3:0]];
      if (bus.s_cyc_o & bus.s_stb_o & bus.s_we_o & ~slv_ack)
        slv_mem[bus.s_adr_o[3:0]] <= bus.s_dat_o;
    end
  end
  assign bus.s_ack_i = slv_ack | ack_force;
  assign bus.s_dat_i = slv_rdat;

  // Single-register slave for the one-master arbiter.
  logic          slv1_ack;
  logic [DW-1:0] slv1_reg;
  logic [DW-1:0] slv1_rdat;

  always @(posedge clk) begin
    if (rst) begin
      slv1_ack  <= 1'b0;
      slv1_reg  <= '0;
      slv1_rdat <= '0;
    end else begin
      slv1_ack  <= bus1.s_cyc_o & bus1.s_stb_o & ~slv1_ack;
      slv1_rdat <= slv1_reg;
      if (bus1.s_cyc_o & bus1.s_stb_o & bus1.s_we_o & ~slv1_ack) slv1_reg <= bus1.s_dat_o;
    end
  end
  assign bus1.s_ack_i = slv1_ack;
  assign bus1.s_dat_i = slv1_rdat;

  // Reference model: current owner (-1 when idle) and last winner as plain integers.
  int          mo;
  int          ml;
  int          total;
  int          bad;
  logic [N-1:0] acked_q;

  function automatic int model_pick(input logic [N-1:0] req, input int last);
    int k;
    for (int i = 1; i <= int'(N); i++) begin
      k = (last + i) % int'(N);
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the model from the inputs sampled at that edge.
  task automatic tick();
    int no;
    int nl;
    int p;
    no = mo;
    nl = ml;
    if (rst) begin
      no = -1;
      nl = int'(N) - 1;
    end else if (mo < 0) begin
      p = model_pick(bus.m_cyc_i, ml);
      if (p >= 0) begin
        no = p;
        nl = p;
      end
    end else if (!bus.m_cyc_i[mo]) begin
      no = -1;
    end
    acked_q = bus.m_ack_o;
    @(posedge clk);
    #1;
    mo = no;
    ml = nl;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]     eg;
    logic [N-1:0]     ea;
    logic [SLV_W-1:0] es;
    logic             c;
    #1;
    eg = '0;
    ea = '0;
    es = '0;
    if (mo >= 0) begin
      c      = bus.m_cyc_i[mo];
      eg[mo] = 1'b1;
      if (c && bus.s_ack_i) ea[mo] = 1'b1;
      es = {c, c & bus.m_stb_i[mo], bus.m_we_i[mo], bus.m_adr_i[mo*AW +: AW],
            bus.m_dat_i[mo*DW +: DW], bus.m_sel_i[mo*SW +: SW]};
    end
    chk({tag, "_gnt"}, 128'(bus.gnt_o), 128'(eg));
    chk({tag, "_busy"}, 128'(bus.busy_o), 128'(mo >= 0));
    chk({tag, "_slv"}, 128'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o,
                             bus.s_dat_o, bus.s_sel_o}), 128'(es));
    chk({tag, "_ack"}, 128'(bus.m_ack_o), 128'(ea));
    chk({tag, "_rdat"}, 128'(bus.m_dat_o), 128'(bus.s_dat_i));
  endtask

  task automatic set_m(input int k, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sl);
    bus.m_cyc_i[k]           = c;
    bus.m_stb_i[k]           = s;
    bus.m_we_i[k]            = w;
    bus.m_adr_i[k*AW +: AW]  = a;
    bus.m_dat_i[k*DW +: DW]  = d;
    bus.m_sel_i[k*SW +: SW]  = sl;
  endtask

  task automatic wait_ack(input string tag, input int k);
    int n;
    n = 0;
    check_all(tag);
    while (!bus.m_ack_o[k] && n < 12) begin
      tick();
      check_all(tag);
      n++;
    end
    chk({tag, "_ack_seen"}, 128'(bus.m_ack_o[k]), 128'(1'b1));
  endtask

  initial begin
    int           e;
    int           lat;
    logic [N-1:0] eg;

    total = 0;
    bad   = 0;
    mo    = -1;
    ml    = int'(N) - 1;
    ack_force = 1'b0;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus1.m_cyc_i = '0; bus1.m_stb_i = '0; bus1.m_we_i = '0;
    bus1.m_adr_i = '0; bus1.m_dat_i = '0; bus1.m_sel_i = '0;

    rst = 1'b1;
    tick();
    tick();
    check_all("reset");
    rst = 1'b0;

    // Single write from master 1.
    set_m(1, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 8'h0F);
    check_all("t1_pre");
    tick();
    chk("t1_gnt", 128'(bus.gnt_o), 128'(4'b0010));
    wait_ack("t1", 1);
    chk("t1_ack_only", 128'(bus.m_ack_o), 128'(4'b0010));
    tick();
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check_all("t1_rel");
    tick();
    check_all("t1_idle");
    chk("t1_mem", 128'(slv_mem[0]), 128'(32'hDEADBEEF));

    // All four request continuously: rotation 0,1,2,3,0 with an idle gap between owners.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < int'(N); k++) set_m(k, 1'b1, 1'b1, 1'b0, AW'(k * 4), '0, '1);
    for (int j = 0; j < 5; j++) begin
      e = j % int'(N);
      tick();
      eg    = '0;
      eg[e] = 1'b1;
      chk($sformatf("t2_order%0d", j), 128'(bus.gnt_o), 128'(eg));
      wait_ack("t2", e);
      tick();
      set_m(e, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      chk($sformatf("t2_gap%0d", j), 128'(bus.gnt_o), 128'(4'b0000));
      set_m(e, 1'b1, 1'b1, 1'b0, AW'(e * 4), '0, '1);
    end
    for (int k = 0; k < int'(N); k++) set_m(k, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Master 0 stalls while master 2 owns the bus.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_m(2, 1'b1, 1'b1, 1'b0, 16'h0004, '0, '1);
    tick();
    chk("t3_gnt2", 128'(bus.gnt_o), 128'(4'b0100));
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h0008, '0, '1);
    for (int j = 0; j < 4; j++) begin
      check_all("t3_hold");
      chk("t3_no_ack0", 128'(bus.m_ack_o[0]), 128'(1'b0));
      tick();
    end
    set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("t3_gap", 128'(bus.gnt_o), 128'(4'b0000));
    tick();
    chk("t3_gnt0", 128'(bus.gnt_o), 128'(4'b0001));
    wait_ack("t3_m0", 0);
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Reset while master 3 waits for ACK; pointer returns to the top index.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_m(3, 1'b1, 1'b1, 1'b1, 16'h0003, 32'h12345678, '1);
    tick();
    chk("t4_gnt3", 128'(bus.gnt_o), 128'(4'b1000));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_force = 1'b1;
    check_all("t4_after_rst");
    chk("t4_scyc", 128'(bus.s_cyc_o), 128'(1'b0));
    chk("t4_ack", 128'(bus.m_ack_o), 128'(4'b0000));
    ack_force = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h0001, '0, '1);
    tick();
    chk("t4_ptr", 128'(bus.gnt_o), 128'(4'b0010));
    wait_ack("t4_m1", 1);
    tick();
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    chk("t4_gnt3b", 128'(bus.gnt_o), 128'(4'b1000));
    wait_ack("t4_m3", 3);
    tick();
    set_m(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Owner drops CYC in the same cycle the slave ACKs.
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h0002, '0, '1);
    tick();
    check_all("t5_own");
    set_m(0, 1'b0, 1'b1, 1'b0, 16'h0002, '0, '1);
    ack_force = 1'b1;
    check_all("t5_drop");
    chk("t5_ack0", 128'(bus.m_ack_o), 128'(4'b0000));
    chk("t5_busy", 128'(bus.busy_o), 128'(1'b1));
    tick();
    ack_force = 1'b0;
    chk("t5_idle", 128'(bus.busy_o), 128'(1'b0));
    check_all("t5_after");
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Randomized traffic: masters request, finish on ACK, occasionally abort.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (bus.m_cyc_i[k]) begin
          if (acked_q[k] || $urandom_range(31) == 0)
            set_m(k, 1'b0, 1'($urandom_range(1)), 1'b0, '0, '0, '0);
        end else if ($urandom_range(3) == 0) begin
          set_m(k, 1'b1, 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                AW'($urandom), DW'($urandom), SW'($urandom));
        end else begin
          bus.m_stb_i[k] = 1'($urandom_range(1));
        end
      end
      check_all("rand");
      tick();
    end
    for (int k = 0; k < int'(N); k++) set_m(k, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    check_all("rand_end");

    // Single-master arbiter: one write then reads, each with fixed latency and an idle gap.
    for (int j = 0; j < 4; j++) begin
      bus1.m_cyc_i = 1'b1;
      bus1.m_stb_i = 1'b1;
      bus1.m_we_i  = 1'(j == 0);
      bus1.m_adr_i = '0;
      bus1.m_dat_i = 32'hDEADBEEF;
      bus1.m_sel_i = '1;
      lat = 0;
      #1;
      while (!bus1.m_ack_o[0] && lat < 12) begin
        tick();
        lat++;
      end
      chk($sformatf("t6_lat%0d", j), 128'(lat), 128'(2));
      if (j > 0) chk($sformatf("t6_rdat%0d", j), 128'(bus1.m_dat_o), 128'(32'hDEADBEEF));
      tick();
      bus1.m_cyc_i = 1'b0;
      bus1.m_stb_i = 1'b0;
      tick();
      chk($sformatf("t6_idle%0d", j), 128'({bus1.busy_o, bus1.gnt_o, bus1.s_cyc_o}), 128'(3'b000));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
